// File: rtl/frame_pattern_detect.sv
// Configurable serial pattern detector: framed (non-overlapping W-bit groups) or
// sliding (overlapping W-bit window) detection with valid qualifier and match counter.
module frame_pattern_detect #(
  parameter int             W       = 6,
  parameter logic [W-1:0]   PATTERN = 6'b011100,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_load,
  input  logic [W-1:0]     cfg_pattern,
  input  logic [W-1:0]     cfg_mask,
  input  logic             cfg_mode,
  input  logic             data_valid,
  input  logic             data,
  input  logic             cnt_clr,
  output logic             match,
  output logic             not_match,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int BW = $clog2(W);
  localparam logic [BW-1:0] LAST = BW'(W - 1);

  typedef enum logic [1:0] {FRAME, FILL, RUN} state_t;

  state_t            state_reg, state_next;
  logic [W-1:0]      pat_reg, pat_next;
  logic [W-1:0]      mask_reg, mask_next;
  logic              mode_reg, mode_next;
  logic [BW-1:0]     bit_cnt_reg, bit_cnt_next;
  logic              fail_reg, fail_next;
  logic [BW-1:0]     fill_cnt_reg, fill_cnt_next;
  logic [W-1:0]      sh_reg, sh_next;
  logic              match_reg, match_next;
  logic              not_match_reg, not_match_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  // Framed compare: bit index i of the frame is checked against pattern bit W-1-i.
  logic [BW-1:0] frame_idx;
  logic          bit_miss;
  logic [W-1:0]  sh_shift;
  logic          win_ok;

  assign frame_idx = LAST - bit_cnt_reg;
  assign bit_miss  = mask_reg[frame_idx] & (data ^ pat_reg[frame_idx]);
  assign sh_shift  = {sh_reg[W-2:0], data};
  assign win_ok    = ((sh_shift ^ pat_reg) & mask_reg) == '0;

  always_comb begin
    state_next     = state_reg;
    pat_next       = pat_reg;
    mask_next      = mask_reg;
    mode_next      = mode_reg;
    bit_cnt_next   = bit_cnt_reg;
    fail_next      = fail_reg;
    fill_cnt_next  = fill_cnt_reg;
    sh_next        = sh_reg;
    match_next     = 1'b0;
    not_match_next = 1'b0;

    if (cfg_load) begin
      pat_next      = cfg_pattern;
      mask_next     = cfg_mask;
      mode_next     = cfg_mode;
      bit_cnt_next  = '0;
      fail_next     = 1'b0;
      fill_cnt_next = '0;
      sh_next       = '0;
      state_next    = cfg_mode ? FILL : FRAME;
    end else if (data_valid) begin
      case (state_reg)
        FRAME: begin
          if (bit_cnt_reg == LAST) begin
            if (!fail_reg && !bit_miss) match_next = 1'b1;
            else                        not_match_next = ~mode_reg;
            bit_cnt_next = '0;
            fail_next    = 1'b0;
          end else begin
            bit_cnt_next = bit_cnt_reg + BW'(1);
            fail_next    = fail_reg | bit_miss;
          end
        end
        FILL: begin
          sh_next = sh_shift;
          if (fill_cnt_reg == LAST) begin
            state_next = RUN;
            match_next = win_ok;
          end else begin
            fill_cnt_next = fill_cnt_reg + BW'(1);
          end
        end
        RUN: begin
          sh_next    = sh_shift;
          match_next = win_ok;
        end
        default: state_next = FRAME;
      endcase
    end

    // Counter follows the registered pulse, so a clear coinciding with it wins.
    cnt_next = cnt_reg;
    if (cnt_clr)                        cnt_next = '0;
    else if (match_reg && cnt_reg != '1) cnt_next = cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= FRAME;
      pat_reg       <= PATTERN;
      mask_reg      <= '1;
      mode_reg      <= 1'b0;
      bit_cnt_reg   <= '0;
      fail_reg      <= 1'b0;
      fill_cnt_reg  <= '0;
      sh_reg        <= '0;
      match_reg     <= 1'b0;
      not_match_reg <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      pat_reg       <= pat_next;
      mask_reg      <= mask_next;
      mode_reg      <= mode_next;
      bit_cnt_reg   <= bit_cnt_next;
      fail_reg      <= fail_next;
      fill_cnt_reg  <= fill_cnt_next;
      sh_reg        <= sh_next;
      match_reg     <= match_next;
      not_match_reg <= not_match_next;
      cnt_reg       <= cnt_next;
    end
  end

  assign match     = match_reg;
  assign not_match = not_match_reg;
  assign match_cnt = cnt_reg;

endmodule

// File: tb/tb_frame_pattern_detect.sv
// Vector-table bench for frame_pattern_detect: a default W=6 instance and a
// W=4 / CNT_W=2 instance for sliding-mode and counter saturation checks.
module tb_frame_pattern_detect;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_ld, a_mode, a_v, a_d, a_clr, a_match, a_nm;
  logic [5:0] a_pat, a_msk;
  logic [7:0] a_cnt;
  logic       b_ld, b_mode, b_v, b_d, b_clr, b_match, b_nm;
  logic [3:0] b_pat, b_msk;
  logic [1:0] b_cnt;

  frame_pattern_detect #(.W(6), .PATTERN(6'b011100), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .cfg_load(a_ld), .cfg_pattern(a_pat),
    .cfg_mask(a_msk), .cfg_mode(a_mode), .data_valid(a_v), .data(a_d),
    .cnt_clr(a_clr), .match(a_match), .not_match(a_nm), .match_cnt(a_cnt)
  );

  frame_pattern_detect #(.W(4), .PATTERN(4'b0101), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .cfg_load(b_ld), .cfg_pattern(b_pat),
    .cfg_mask(b_msk), .cfg_mode(b_mode), .data_valid(b_v), .data(b_d),
    .cnt_clr(b_clr), .match(b_match), .not_match(b_nm), .match_cnt(b_cnt)
  );

  typedef struct {
    int          dut;
    logic        ld;
    logic [31:0] pat;
    logic [31:0] msk;
    logic        mode;
    logic        v;
    logic        d;
    logic        clr;
    logic        em;
    logic        enm;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vq[$];
  vec_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   vec_no  = 0;

  function automatic void add(input int dut, input logic ld, input logic [31:0] pat,
                              input logic [31:0] msk, input logic mode, input logic v,
                              input logic d, input logic clr, input logic em,
                              input logic enm, input logic [31:0] ecnt);
    vec_t r;
    r.dut = dut; r.ld = ld; r.pat = pat; r.msk = msk; r.mode = mode;
    r.v = v; r.d = d; r.clr = clr; r.em = em; r.enm = enm; r.ecnt = ecnt;
    vq.push_back(r);
  endfunction

  function automatic void dbit(input int dut, input logic d, input logic em,
                               input logic enm, input logic [31:0] ecnt);
    add(dut, 1'b0, 0, 0, 1'b0, 1'b1, d, 1'b0, em, enm, ecnt);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle();
    a_ld = 0; a_mode = 0; a_v = 0; a_d = 0; a_clr = 0; a_pat = '0; a_msk = '0;
    b_ld = 0; b_mode = 0; b_v = 0; b_d = 0; b_clr = 0; b_pat = '0; b_msk = '0;
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    idle();
    if (v.dut == 0) begin
      a_ld = v.ld; a_pat = v.pat[5:0]; a_msk = v.msk[5:0]; a_mode = v.mode;
      a_v = v.v; a_d = v.d; a_clr = v.clr;
    end else begin
      b_ld = v.ld; b_pat = v.pat[3:0]; b_msk = v.msk[3:0]; b_mode = v.mode;
      b_v = v.v; b_d = v.d; b_clr = v.clr;
    end
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    if (e.dut == 0) begin
      check($sformatf("v%0d.a.match", vec_no), 32'(a_match), 32'(e.em));
      check($sformatf("v%0d.a.not_match", vec_no), 32'(a_nm), 32'(e.enm));
      check($sformatf("v%0d.a.match_cnt", vec_no), 32'(a_cnt), e.ecnt);
    end else begin
      check($sformatf("v%0d.b.match", vec_no), 32'(b_match), 32'(e.em));
      check($sformatf("v%0d.b.not_match", vec_no), 32'(b_nm), 32'(e.enm));
      check($sformatf("v%0d.b.match_cnt", vec_no), 32'(b_cnt), e.ecnt);
    end
    $display("[TB] vec %0d dut=%0d ld=%0b v=%0b d=%0b clr=%0b -> match=%0b nm=%0b",
             vec_no, e.dut, e.ld, e.v, e.d, e.clr,
             (e.dut == 0) ? a_match : b_match, (e.dut == 0) ? a_nm : b_nm);
    vec_no++;
  endtask

  task automatic run_vecs();
    foreach (vq[i]) step(vq[i]);
    vq.delete();
  endtask

  initial begin
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("reset.a.match", 32'(a_match), 0);
    check("reset.a.not_match", 32'(a_nm), 0);
    check("reset.a.match_cnt", 32'(a_cnt), 0);
    check("reset.b.match", 32'(b_match), 0);
    check("reset.b.match_cnt", 32'(b_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Defaults: 011100 matches, 011101 fails on its last bit.
    dbit(0,0,0,0,0); dbit(0,1,0,0,0); dbit(0,1,0,0,0); dbit(0,1,0,0,0); dbit(0,0,0,0,0); dbit(0,0,1,0,0);
    dbit(0,0,0,0,1); dbit(0,1,0,0,1); dbit(0,1,0,0,1); dbit(0,1,0,0,1); dbit(0,0,0,0,1); dbit(0,1,0,1,1);
    // Valid gaps between bits 2 and 3.
    dbit(0,0,0,0,1); dbit(0,1,0,0,1);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    dbit(0,1,0,0,1); dbit(0,1,0,0,1); dbit(0,0,0,0,1); dbit(0,0,1,0,1);
    // Mask 111100: 011111 matches, 111100 fails on bit 0.
    add(0, 1, 6'b011100, 6'b111100, 0, 1, 1, 0, 0, 0, 2);
    dbit(0,0,0,0,2); dbit(0,1,0,0,2); dbit(0,1,0,0,2); dbit(0,1,0,0,2); dbit(0,1,0,0,2); dbit(0,1,1,0,2);
    dbit(0,1,0,0,3); dbit(0,1,0,0,3); dbit(0,1,0,0,3); dbit(0,1,0,0,3); dbit(0,0,0,0,3); dbit(0,0,0,1,3);
    // Abort after 3 bits: cfg_load with valid data discards that bit, no pulse.
    dbit(0,0,0,0,3); dbit(0,1,0,0,3); dbit(0,1,0,0,3);
    add(0, 1, 6'b011100, 6'b111111, 0, 1, 1, 0, 0, 0, 3);
    dbit(0,0,0,0,3); dbit(0,1,0,0,3); dbit(0,1,0,0,3); dbit(0,1,0,0,3); dbit(0,0,0,0,3); dbit(0,0,1,0,3);
    // cnt_clr coinciding with a visible match: clear wins.
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // All-zero mask: every frame end matches.
    add(0, 1, 6'b011100, 6'b000000, 0, 0, 0, 0, 0, 0, 0);
    dbit(0,1,0,0,0); dbit(0,0,0,0,0); dbit(0,1,0,0,0); dbit(0,0,0,0,0); dbit(0,1,0,0,0); dbit(0,0,1,0,0);
    dbit(0,1,0,0,1); dbit(0,1,0,0,1); dbit(0,1,0,0,1);
    run_vecs();

    // Asynchronous reset mid-frame: outputs clear at once, config returns to defaults.
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.a.match_cnt", 32'(a_cnt), 0);
    check("async_rst.a.match", 32'(a_match), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dbit(0,0,0,0,0); dbit(0,1,0,0,0); dbit(0,1,0,0,0); dbit(0,1,0,0,0); dbit(0,0,0,0,0); dbit(0,0,1,0,0);
    dbit(0,1,0,0,1); dbit(0,1,0,0,1); dbit(0,1,0,0,1); dbit(0,1,0,0,1); dbit(0,1,0,0,1); dbit(0,1,0,1,1);

    // Sliding W=4, pattern 0101: overlapping matches, then 2-bit counter saturation.
    add(1, 1, 4'b0101, 4'b1111, 1, 0, 0, 0, 0, 0, 0);
    dbit(1,0,0,0,0); dbit(1,1,0,0,0); dbit(1,0,0,0,0); dbit(1,1,1,0,0);
    dbit(1,0,0,0,1); dbit(1,1,1,0,1); dbit(1,0,0,0,2);
    dbit(1,1,1,0,2); dbit(1,0,0,0,3); dbit(1,1,1,0,3); dbit(1,0,0,0,3);
    dbit(1,1,1,0,3); dbit(1,0,0,0,3);
    run_vecs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
